uart_rx_frame: RTL and testbench

//  UART receive framer. Sits directly downstream of the control-register core and consumes its

---
 rtl/uart_rx_frame_if.sv | 37 +++
 rtl/uart_rx_frame.sv | 203 ++++++++++++++++++++
 tb/tb_uart_rx_frame.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_frame_if.sv
// uart_rx_frame_if: serial line, frame configuration and received-frame status
// for the UART receive framer. The optional break output exists only when
// RX_BREAK_DETECT_EN is defined.
interface uart_rx_frame_if;
  logic        Rx_i;
  logic [11:0] AcqPeriod_i;
  logic [7:0]  BitCompensation_i;
  logic        p_ParityEnable_i;
  logic        p_BigEnd_i;
  logic        ParityMethod_i;
  logic [7:0]  Data_o;
  logic        p_DataValid_o;
  logic        p_ParityErr_o;
  logic        p_FrameErr_o;
  logic        p_Busy_o;
`ifdef RX_BREAK_DETECT_EN
  logic        p_Break_o;

  modport master (
    output Rx_i, AcqPeriod_i, BitCompensation_i, p_ParityEnable_i, p_BigEnd_i, ParityMethod_i,
    input  Data_o, p_DataValid_o, p_ParityErr_o, p_FrameErr_o, p_Busy_o, p_Break_o
  );
  modport slave (
    input  Rx_i, AcqPeriod_i, BitCompensation_i, p_ParityEnable_i, p_BigEnd_i, ParityMethod_i,
    output Data_o, p_DataValid_o, p_ParityErr_o, p_FrameErr_o, p_Busy_o, p_Break_o
  );
`else
  modport master (
    output Rx_i, AcqPeriod_i, BitCompensation_i, p_ParityEnable_i, p_BigEnd_i, ParityMethod_i,
    input  Data_o, p_DataValid_o, p_ParityErr_o, p_FrameErr_o, p_Busy_o
  );
  modport slave (
    input  Rx_i, AcqPeriod_i, BitCompensation_i, p_ParityEnable_i, p_BigEnd_i, ParityMethod_i,
    output Data_o, p_DataValid_o, p_ParityErr_o, p_FrameErr_o, p_Busy_o
  );
`endif
endinterface

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: UART receive framer. Synchronises Rx, validates the start bit,
// majority-votes every bit over a programmable sample window and reports one
// byte per frame with parity and framing status.
// Optional feature macro: RX_BREAK_DETECT_EN (break pulse + wait for idle line).
module uart_rx_frame #(
  parameter logic [11:0] MIN_PERIOD = 12'd4,
  parameter int          DATA_BITS  = 8
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_frame_if.slave bus
);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    DONE    = 3'd5,
    BRKWAIT = 3'd6
  } state_t;

  state_t state, stateNext;

  logic rxMeta, rxS, rxPrev;
  logic fallEdge;

  // Frame configuration captured when a start edge is accepted
  logic [11:0] periodLat, upLat, downLat;
  logic        singleLat, parEnLat, bigEndLat, oddLat;

  // Configuration as it would be captured this cycle
  logic [11:0] pEff, upRaw, downRaw, upEff, downEff;

  logic [11:0] cnt, halfP;
  logic [4:0]  ones, samples;
  logic        lastCnt, inWin, vote, stopDecide, stopVal;

  logic [IDX_W-1:0]     bitIdx;
  logic [DATA_BITS-1:0] shReg, shNext, dataReg;
  logic                 parBit, parErrReg, frameErrReg;
  logic                 busyC, validC;
`ifdef RX_BREAK_DETECT_EN
  logic brkReg, breakC;
`endif

  assign fallEdge = rxPrev & ~rxS;

  assign pEff    = (bus.AcqPeriod_i < MIN_PERIOD) ? MIN_PERIOD : bus.AcqPeriod_i;
  assign upRaw   = {8'd0, bus.BitCompensation_i[7:4]};
  assign downRaw = {8'd0, bus.BitCompensation_i[3:0]};
  assign upEff   = (upRaw > pEff - 12'd1) ? pEff - 12'd1 : upRaw;
  assign downEff = (downRaw > pEff - 12'd1) ? pEff - 12'd1 : downRaw;

  // The window always ends before P-1, so the per-bit decision at P-1 sees a complete tally
  assign halfP      = periodLat >> 1;
  assign lastCnt    = (cnt == periodLat - 12'd1);
  assign inWin      = singleLat ? (cnt == halfP) : ((cnt >= downLat) && (cnt < upLat));
  assign vote       = ({ones, 1'b0} >= {1'b0, samples});
  // Stop bit is judged at the window end so the receiver re-arms early
  assign stopDecide = singleLat ? (cnt == halfP) : (cnt == upLat);
  assign stopVal    = singleLat ? rxS : vote;

  // Shift-in of the voted bit, LSB-first or MSB-first
  genvar gi;
  generate
    for (gi = 0; gi < DATA_BITS; gi++) begin : g_shift
      if (gi == 0) begin : g_lo
        assign shNext[gi] = bigEndLat ? vote : shReg[gi+1];
      end else if (gi == DATA_BITS - 1) begin : g_hi
        assign shNext[gi] = bigEndLat ? shReg[gi-1] : vote;
      end else begin : g_mid
        assign shNext[gi] = bigEndLat ? shReg[gi-1] : shReg[gi+1];
      end
    end
  endgenerate

  // Two-flop synchroniser plus edge-detect history, preset to the idle level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxMeta <= 1'b1;
      rxS    <= 1'b1;
      rxPrev <= 1'b1;
    end else begin
      rxMeta <= bus.Rx_i;
      rxS    <= rxMeta;
      rxPrev <= rxS;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  // FSM next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (fallEdge) stateNext = START;
      START:   if (lastCnt) stateNext = vote ? IDLE : DATA;
      DATA:    if (lastCnt && (bitIdx == LAST_IDX)) stateNext = parEnLat ? PARITY : STOP;
      PARITY:  if (lastCnt) stateNext = STOP;
      STOP:    if (stopDecide) stateNext = DONE;
`ifdef RX_BREAK_DETECT_EN
      DONE:    stateNext = brkReg ? BRKWAIT : IDLE;
      BRKWAIT: if (rxS) stateNext = IDLE;
`else
      DONE:    stateNext = IDLE;
`endif
      default: stateNext = IDLE;
    endcase
  end

  // FSM outputs decoded from state
  always_comb begin
    busyC  = (state != IDLE);
    validC = (state == DONE);
`ifdef RX_BREAK_DETECT_EN
    breakC = (state == DONE) && brkReg;
`endif
  end

  // Bit timing, voting, shifting and frame result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      ones        <= '0;
      samples     <= '0;
      bitIdx      <= '0;
      periodLat   <= '0;
      upLat       <= '0;
      downLat     <= '0;
      singleLat   <= 1'b0;
      parEnLat    <= 1'b0;
      bigEndLat   <= 1'b0;
      oddLat      <= 1'b0;
      shReg       <= '0;
      dataReg     <= '0;
      parBit      <= 1'b0;
      parErrReg   <= 1'b0;
      frameErrReg <= 1'b0;
`ifdef RX_BREAK_DETECT_EN
      brkReg      <= 1'b0;
`endif
    end else if (state == IDLE) begin
      cnt     <= '0;
      ones    <= '0;
      samples <= '0;
      bitIdx  <= '0;
      if (fallEdge) begin
        periodLat <= pEff;
        upLat     <= upEff;
        downLat   <= downEff;
        singleLat <= (upEff <= downEff);
        parEnLat  <= bus.p_ParityEnable_i;
        bigEndLat <= bus.p_BigEnd_i;
        oddLat    <= bus.ParityMethod_i;
        parBit    <= 1'b0;
      end
    end else begin
      if (lastCnt) begin
        cnt     <= '0;
        ones    <= '0;
        samples <= '0;
      end else begin
        cnt <= cnt + 12'd1;
        if (inWin) begin
          samples <= samples + 5'd1;
          ones    <= ones + {4'd0, rxS};
        end
      end
      if ((state == DATA) && lastCnt) begin
        shReg  <= shNext;
        bitIdx <= bitIdx + IDX_ONE;
      end
      if ((state == PARITY) && lastCnt) parBit <= vote;
      if ((state == STOP) && stopDecide) begin
        dataReg     <= shReg;
        parErrReg   <= parEnLat & (^shReg ^ parBit ^ oddLat);
        frameErrReg <= ~stopVal;
`ifdef RX_BREAK_DETECT_EN
        brkReg      <= (shReg == '0) & (~parEnLat | ~parBit) & ~stopVal;
`endif
      end
    end
  end

  assign bus.Data_o        = dataReg;
  assign bus.p_DataValid_o = validC;
  assign bus.p_ParityErr_o = parErrReg;
  assign bus.p_FrameErr_o  = frameErrReg;
  assign bus.p_Busy_o      = busyC;
`ifdef RX_BREAK_DETECT_EN
  assign bus.p_Break_o     = breakC;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed and randomized frames against a frame-level model
// of uart_rx_frame (expected byte, flags and valid cycle per frame).
module tb_uart_rx_frame;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_frame_if busIf();
  uart_rx_frame dut (.clk(clk), .rst(rst), .bus(busIf.slave));

  typedef struct {
    logic [7:0] data;
    bit         perr;
    bit         ferr;
    bit         brk;
    int         cyc;
  } exp_t;

  exp_t       expQ[$];
  bit         lineQ[$];
  logic [9:0] heldExp = '0;

  logic [11:0] cfgPeriod;
  logic [7:0]  cfgComp;
  bit          cfgParEn, cfgBig, cfgOdd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int effP(input logic [11:0] raw);
    return (raw < 12'd4) ? 4 : int'(raw);
  endfunction

  // Count (within the stop bit) at which the stop level is judged
  function automatic int stopDec();
    int p, up, dn;
    p  = effP(cfgPeriod);
    up = (int'(cfgComp[7:4]) > p - 1) ? p - 1 : int'(cfgComp[7:4]);
    dn = (int'(cfgComp[3:0]) > p - 1) ? p - 1 : int'(cfgComp[3:0]);
    return (up <= dn) ? p / 2 : up;
  endfunction

  task automatic applyCfg(input logic [11:0] per, input logic [7:0] comp,
                          input bit parEn, input bit big, input bit odd);
    cfgPeriod = per; cfgComp = comp; cfgParEn = parEn; cfgBig = big; cfgOdd = odd;
    busIf.AcqPeriod_i       = per;
    busIf.BitCompensation_i = comp;
    busIf.p_ParityEnable_i  = parEn;
    busIf.p_BigEnd_i        = big;
    busIf.ParityMethod_i    = odd;
  endtask

  // Drive one frame bit-by-bit, P clocks per bit, followed by an idle gap
  task automatic sendFrame(input logic [7:0] d, input bit badPar, input bit stopBit,
                           input int glitchBit, input int abortAt, input bit scramble);
    int p, nb, dec, idx;
    bit par;
    exp_t e;
    p = effP(cfgPeriod);
    lineQ.delete();
    repeat (p) lineQ.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      bit b;
      b = cfgBig ? d[7-i] : d[i];
      repeat (p) lineQ.push_back(b);
    end
    par = (^d) ^ cfgOdd ^ badPar;
    if (cfgParEn) repeat (p) lineQ.push_back(par);
    repeat (p) lineQ.push_back(stopBit);
    repeat (2 * p + 3) lineQ.push_back(1'b1);
    if (glitchBit >= 0) begin
      idx = (1 + glitchBit) * p + 7;
      lineQ[idx]     = ~lineQ[idx];
      lineQ[idx + 1] = ~lineQ[idx + 1];
    end
    e.data = d;
    e.perr = cfgParEn && (((($countones(d) + int'(par)) % 2) != (cfgOdd ? 1 : 0)));
    e.ferr = !stopBit;
    e.brk  = (d == 8'h00) && (!cfgParEn || !par) && !stopBit;
    nb  = cfgParEn ? 10 : 9;
    dec = stopDec();
    for (int i = 0; i < lineQ.size(); i++) begin
      @(posedge clk); #1;
      busIf.Rx_i = lineQ[i];
      if (i == 0) begin
        // sync (2) + edge detect (1) + count + one cycle to the valid pulse
        e.cyc = cyc + nb * p + dec + 4;
        if (abortAt < 0) expQ.push_back(e);
      end
      if (i == abortAt) return;
      if (scramble && (i == 2 * p)) begin
        busIf.AcqPeriod_i       = 12'($urandom);
        busIf.BitCompensation_i = 8'($urandom);
        busIf.p_ParityEnable_i  = 1'($urandom);
        busIf.p_BigEnd_i        = 1'($urandom);
        busIf.ParityMethod_i    = 1'($urandom);
      end
    end
    check("valid_seen", expQ.size(), 0);
  endtask

  // Compare process: every valid pulse against the model, held outputs otherwise
  always @(negedge clk) begin
    exp_t e;
    bit   brkExp;
    brkExp = 1'b0;
    if (!rst) begin
      heldExp = '0;
    end else begin
      if (busIf.p_DataValid_o) begin
        if (expQ.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_valid: got valid=1, expected no pending frame (cycle %0d)", cyc);
        end else begin
          e = expQ.pop_front();
          check("data", busIf.Data_o, e.data);
          check("parity_err", busIf.p_ParityErr_o, e.perr);
          check("frame_err", busIf.p_FrameErr_o, e.ferr);
          check("latency", cyc, e.cyc);
          heldExp = {e.data, e.perr, e.ferr};
          brkExp  = e.brk;
        end
      end else begin
        check("held", {busIf.Data_o, busIf.p_ParityErr_o, busIf.p_FrameErr_o}, heldExp);
      end
`ifdef RX_BREAK_DETECT_EN
      check("break", busIf.p_Break_o, brkExp);
`endif
    end
  end

  initial begin
    busIf.Rx_i = 1'b1;
    applyCfg(12'd20, 8'hA5, 1'b1, 1'b0, 1'b1);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", busIf.Data_o, 8'h00);
    check("rst_valid", busIf.p_DataValid_o, 0);
    check("rst_busy", busIf.p_Busy_o, 0);
    check("rst_flags", {busIf.p_ParityErr_o, busIf.p_FrameErr_o}, 0);
    rst = 1'b1;
    repeat (4) @(posedge clk);

    // 1: basic LSB-first frame, odd parity
    sendFrame(8'hA5, 1'b0, 1'b1, -1, -1, 1'b0);
    check("t1_data", busIf.Data_o, 8'hA5);
    check("t1_flags", {busIf.p_ParityErr_o, busIf.p_FrameErr_o}, 2'b00);

    // 2: MSB-first
    applyCfg(12'd20, 8'hA5, 1'b1, 1'b1, 1'b1);
    sendFrame(8'hA5, 1'b0, 1'b1, -1, -1, 1'b0);
    check("t2_data", busIf.Data_o, 8'hA5);

    // 3: wrong parity bit, then parity disabled
    applyCfg(12'd20, 8'hA5, 1'b1, 1'b0, 1'b1);
    sendFrame(8'hA5, 1'b1, 1'b1, -1, -1, 1'b0);
    check("t3_perr", busIf.p_ParityErr_o, 1);
    check("t3_data", busIf.Data_o, 8'hA5);
    applyCfg(12'd20, 8'hA5, 1'b0, 1'b0, 1'b1);
    sendFrame(8'hA5, 1'b0, 1'b1, -1, -1, 1'b0);
    check("t3_perr_off", busIf.p_ParityErr_o, 0);

    // 4: framing error then a clean frame
    applyCfg(12'd20, 8'hA5, 1'b1, 1'b0, 1'b1);
    sendFrame(8'h3C, 1'b0, 1'b0, -1, -1, 1'b0);
    check("t4_ferr", busIf.p_FrameErr_o, 1);
    check("t4_data", busIf.Data_o, 8'h3C);
    sendFrame(8'h3C, 1'b0, 1'b1, -1, -1, 1'b0);
    check("t4_ferr_clr", busIf.p_FrameErr_o, 0);

    // 5: 3-clock low pulse is a false start; 2-clock glitch inside a window is voted out
    for (int i = 0; i < 45; i++) begin
      @(posedge clk); #1;
      busIf.Rx_i = (i < 3) ? 1'b0 : 1'b1;
      if (i == 4)  check("t5_busy_on", busIf.p_Busy_o, 1);
      if (i == 22) check("t5_busy_hold", busIf.p_Busy_o, 1);
      if (i == 23) check("t5_busy_off", busIf.p_Busy_o, 0);
    end
    sendFrame(8'h96, 1'b0, 1'b1, 3, -1, 1'b0);
    check("t5_glitch_data", busIf.Data_o, 8'h96);

    // 6: reset in the middle of data bit 4, then a full frame
    sendFrame(8'hC3, 1'b0, 1'b1, -1, 110, 1'b0);
    rst = 1'b0;
    busIf.Rx_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("t6_rst_data", busIf.Data_o, 8'h00);
    check("t6_rst_busy", busIf.p_Busy_o, 0);
    check("t6_rst_valid", busIf.p_DataValid_o, 0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    sendFrame(8'h5A, 1'b0, 1'b1, -1, -1, 1'b0);
    check("t6_data", busIf.Data_o, 8'h5A);

    // Randomized frames with random period/window/format; config scrambled mid-frame
    for (int n = 0; n < 40; n++) begin
      logic [7:0] d;
      applyCfg(12'($urandom_range(0, 30)), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      d = (n % 10 == 0) ? 8'h00 : 8'($urandom);
      sendFrame(d, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0), -1, -1, 1'b1);
    end

    repeat (5) @(posedge clk);
    check("queue_empty", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
